// File: rtl/tx_msg_feeder.sv
// tx_msg_feeder: queues {sf, msg} entries and launches them one frame at a
// time into the DCSK transmitter, sequencing on its o_is_sending handshake and
// flagging a transmitter that never starts a launched frame.
module tx_msg_feeder #(
    parameter int DEPTH         = 8,
    parameter int START_TIMEOUT = 4
) (
    input  logic                   i_clk,
    input  logic                   i_arst_n,
    input  logic                   i_wr_en,
    input  logic [31:0]            i_wr_msg,
    input  logic [1:0]             i_wr_sf,
    input  logic                   i_en,
    input  logic                   i_is_sending,
    output logic                   o_send,
    output logic [31:0]            o_msg,
    output logic [1:0]             o_sf,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_ovf,
    output logic                   o_timeout,
    input  logic                   i_clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(START_TIMEOUT + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LAUNCH = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_BUSY   = 3'd3;
    localparam logic [2:0] ST_GAP    = 3'd4;

    logic [33:0]   mem_r [DEPTH];
    logic [CW-1:0] wr_ptr_r;
    logic [CW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_s;
    logic          full_r;
    logic          empty_r;
    logic [2:0]    state_r;
    logic [2:0]    state_s;
    logic [TW-1:0] tmo_cnt_r;
    logic [TW-1:0] tmo_cnt_s;
    logic          send_r;
    logic [31:0]   msg_r;
    logic [1:0]    sf_r;
    logic          ovf_r;
    logic          timeout_r;
    logic          wr_accept_s;
    logic          pop_s;
    logic          tmo_event_s;
    logic [33:0]   head_s;

    // A pop in the same cycle never frees a slot for a write: gate on registered full.
    assign wr_accept_s = i_wr_en && !full_r;
    assign head_s      = mem_r[rd_ptr_r[AW-1:0]];

    // Launch sequencer: next state, pop strobe and start-timeout countdown.
    always_comb begin
        state_s     = state_r;
        tmo_cnt_s   = tmo_cnt_r;
        pop_s       = 1'b0;
        tmo_event_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A transmitter busy with someone else's frame blocks launch.
                if (i_en && !empty_r && !i_is_sending) begin
                    pop_s   = 1'b1;
                    state_s = ST_LAUNCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                tmo_cnt_s = TW'(START_TIMEOUT);
                state_s   = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_is_sending) begin
                    state_s = ST_BUSY;
                end else if (tmo_cnt_r <= TW'(1'b1)) begin
                    // Frame is dropped, not retried.
                    tmo_event_s = 1'b1;
                    tmo_cnt_s   = '0;
                    state_s     = ST_IDLE;
                end else begin
                    tmo_cnt_s = tmo_cnt_r - TW'(1'b1);
                end
            end
            ST_BUSY: begin
                if (!i_is_sending) begin
                    state_s = ST_GAP;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_GAP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Occupancy after this cycle's accepted write and pop.
    always_comb begin
        count_s = count_r + CW'(wr_accept_s) - CW'(pop_s);
    end

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge i_clk) begin
        if (wr_accept_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {i_wr_sf, i_wr_msg};
        end
    end

    // FIFO pointers and registered occupancy flags.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (wr_accept_s) begin
                wr_ptr_r <= wr_ptr_r + CW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + CW'(1'b1);
            end
            count_r <= count_s;
            full_r  <= (count_s == CW'(DEPTH));
            empty_r <= (count_s == '0);
        end
    end

    // Sequencer state, send pulse and the frame registers held until the next pop.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_r   <= ST_IDLE;
            tmo_cnt_r <= '0;
            send_r    <= 1'b0;
            msg_r     <= 32'h0000_0000;
            sf_r      <= 2'b00;
        end else begin
            state_r   <= state_s;
            tmo_cnt_r <= tmo_cnt_s;
            send_r    <= (state_r == ST_LAUNCH);
            if (pop_s) begin
                msg_r <= head_s[31:0];
                sf_r  <= head_s[33:32];
            end
        end
    end

    // Sticky error flags; a new error in the clear cycle keeps the flag set.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            ovf_r     <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            if (i_wr_en && full_r) begin
                ovf_r <= 1'b1;
            end else if (i_clr_err) begin
                ovf_r <= 1'b0;
            end
            if (tmo_event_s) begin
                timeout_r <= 1'b1;
            end else if (i_clr_err) begin
                timeout_r <= 1'b0;
            end
        end
    end

    assign o_send    = send_r;
    assign o_msg     = msg_r;
    assign o_sf      = sf_r;
    assign o_full    = full_r;
    assign o_empty   = empty_r;
    assign o_count   = count_r;
    assign o_ovf     = ovf_r;
    assign o_timeout = timeout_r;

endmodule

// File: tb/tb_tx_msg_feeder.sv
// Scoreboard bench for tx_msg_feeder with a simple transmitter model.
module tb_tx_msg_feeder;

    localparam int DEPTH     = 8;
    localparam int FRAME_LEN = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_msg = 32'h0;
    logic [1:0]  wr_sf = 2'b00;
    logic        en = 1'b0;
    logic        is_sending = 1'b0;
    logic        clr_err = 1'b0;
    logic        o_send;
    logic [31:0] o_msg;
    logic [1:0]  o_sf;
    logic        o_full;
    logic        o_empty;
    logic [3:0]  o_count;
    logic        o_ovf;
    logic        o_timeout;

    tx_msg_feeder #(.DEPTH(DEPTH), .START_TIMEOUT(4)) dut (
        .i_clk(clk), .i_arst_n(rst_n), .i_wr_en(wr_en), .i_wr_msg(wr_msg),
        .i_wr_sf(wr_sf), .i_en(en), .i_is_sending(is_sending), .o_send(o_send),
        .o_msg(o_msg), .o_sf(o_sf), .o_full(o_full), .o_empty(o_empty),
        .o_count(o_count), .o_ovf(o_ovf), .o_timeout(o_timeout), .i_clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [33:0] sb_q[$];
    int exp_send_edge = -1;
    bit gap_chk = 1'b0;
    int fall_edge = -1;
    bit prev_is = 1'b0;
    int tx_left = 0;
    bit tx_conn = 1'b1;
    logic [33:0] last_sent = 34'h0;
    int send_seen = 0;
    int last_send_edge = 0;

    logic [31:0] burst_tab [8] = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'hF0F0_F0F0,
                                   32'hA5A5_5A5A, 32'h0000_0001, 32'h8000_0000, 32'h3C3C_C3C3};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every send pulse and checks frame timing.
    initial begin
        logic [33:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (o_send) begin
                    send_seen++;
                    last_send_edge = cyc;
                    if (sb_q.size() == 0) begin
                        check("unexpected_send", {30'h0, o_sf, o_msg}, 64'h0);
                    end else begin
                        exp = sb_q.pop_front();
                        check("frame_data", {30'h0, o_sf, o_msg}, {30'h0, exp});
                    end
                    last_sent = {o_sf, o_msg};
                    if (exp_send_edge >= 0) begin
                        check("launch_latency", 64'(cyc), 64'(exp_send_edge));
                        exp_send_edge = -1;
                    end
                    if (gap_chk && fall_edge >= 0) begin
                        check("b2b_gap", 64'(cyc), 64'(fall_edge + 3));
                        fall_edge = -1;
                    end
                end
                if (is_sending) check("msg_stable", {30'h0, o_sf, o_msg}, {30'h0, last_sent});
                if (prev_is && !is_sending) fall_edge = cyc;
                prev_is = is_sending;
            end else begin
                prev_is = 1'b0;
            end
        end
    end

    // Transmitter model: busy for FRAME_LEN cycles starting the cycle after a send pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                tx_left = 0;
                is_sending = 1'b0;
            end else if (o_send && tx_conn) begin
                tx_left = FRAME_LEN;
            end else if (tx_left > 0) begin
                is_sending = 1'b1;
                tx_left--;
            end else begin
                is_sending = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [31:0] m, input logic [1:0] s, input bit expect_sent);
        @(negedge clk);
        wr_en = 1'b1;
        wr_msg = m;
        wr_sf = s;
        if (expect_sent) sb_q.push_back({s, m});
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic drain(input string name, input int limit);
        int stable = 0;
        for (int i = 0; i < limit && stable < 8; i++) begin
            tick();
            if (sb_q.size() == 0 && o_empty && !is_sending && tx_left == 0) stable++;
            else stable = 0;
        end
        check({name, "_drained"}, 64'(stable >= 8), 64'h1);
    endtask

    task automatic wait_send(input string name, input int target, output int edge_no);
        for (int i = 0; i < 40 && send_seen < target; i++) tick();
        check(name, 64'(send_seen >= target), 64'h1);
        edge_no = last_send_edge;
    endtask

    task automatic wait_busy(input string name);
        for (int i = 0; i < 40 && !is_sending; i++) tick();
        check(name, 64'(is_sending), 64'h1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_send"}, 64'(o_send), 64'h0);
        check({tag, "_msg"}, 64'(o_msg), 64'h0);
        check({tag, "_sf"}, 64'(o_sf), 64'h0);
        check({tag, "_full"}, 64'(o_full), 64'h0);
        check({tag, "_empty"}, 64'(o_empty), 64'h1);
        check({tag, "_count"}, 64'(o_count), 64'h0);
        check({tag, "_ovf"}, 64'(o_ovf), 64'h0);
        check({tag, "_timeout"}, 64'(o_timeout), 64'h0);
    endtask

    initial begin
        int base;
        int s_edge;
        repeat (3) @(posedge clk);
        #2;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        tick();

        // Single frame: DEADBEEF / SF32
        base = send_seen;
        wr(32'hDEAD_BEEF, 2'd3, 1'b1);
        exp_send_edge = cyc + 2;
        check("single_empty_fall", 64'(o_empty), 64'h0);
        tick();
        check("single_msg", 64'(o_msg), 64'hDEAD_BEEF);
        check("single_sf", 64'(o_sf), 64'h3);
        check("single_no_send_yet", 64'(o_send), 64'h0);
        tick();
        check("single_send", 64'(o_send), 64'h1);
        drain("single", 100);
        check("single_count", 64'(send_seen - base), 64'h1);

        // Burst: fill with launch disabled, then drain in order
        base = send_seen;
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 8; i++) wr(burst_tab[i], 2'(i), 1'b1);
        check("burst_full", 64'(o_full), 64'h1);
        check("burst_count8", 64'(o_count), 64'h8);
        gap_chk = 1'b1;
        fall_edge = -1;
        @(negedge clk);
        en = 1'b1;
        drain("burst", 400);
        gap_chk = 1'b0;
        check("burst_empty", 64'(o_empty), 64'h1);
        check("burst_sent", 64'(send_seen - base), 64'h8);

        // Overflow: 9 writes with launch disabled
        base = send_seen;
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 8; i++) wr(32'h5500_0000 + 32'(i), 2'(3 - (i % 4)), 1'b1);
        check("ovf_before", 64'(o_ovf), 64'h0);
        wr(32'hBAD0_0009, 2'd1, 1'b0);
        check("ovf_count", 64'(o_count), 64'h8);
        check("ovf_set", 64'(o_ovf), 64'h1);
        @(negedge clk);
        wr_en = 1'b1;
        wr_msg = 32'hBAD0_000A;
        clr_err = 1'b1;
        tick();
        wr_en = 1'b0;
        clr_err = 1'b0;
        check("ovf_err_wins", 64'(o_ovf), 64'h1);
        pulse_clr();
        check("ovf_cleared", 64'(o_ovf), 64'h0);
        @(negedge clk);
        en = 1'b1;
        drain("ovf", 400);
        check("ovf_sent", 64'(send_seen - base), 64'h8);

        // Timeout: transmitter never starts
        tx_conn = 1'b0;
        base = send_seen;
        wr(32'h7777_0001, 2'd0, 1'b1);
        wr(32'h7777_0002, 2'd2, 1'b1);
        wait_send("tmo_send1", base + 1, s_edge);
        repeat (3) tick();
        check("tmo1_pre", 64'(o_timeout), 64'h0);
        tick();
        check("tmo1_set", 64'(o_timeout), 64'h1);
        pulse_clr();
        check("tmo1_clr", 64'(o_timeout), 64'h0);
        wait_send("tmo_send2", base + 2, s_edge);
        repeat (3) tick();
        check("tmo2_pre", 64'(o_timeout), 64'h0);
        tick();
        check("tmo2_set", 64'(o_timeout), 64'h1);
        check("tmo_count0", 64'(o_count), 64'h0);
        check("tmo_empty", 64'(o_empty), 64'h1);
        pulse_clr();
        tx_conn = 1'b1;

        // Enable gating: drop en during the first of 3 frames
        base = send_seen;
        wr(32'hE000_0001, 2'd1, 1'b1);
        wr(32'hE000_0002, 2'd2, 1'b1);
        wr(32'hE000_0003, 2'd3, 1'b1);
        wait_busy("gate_busy");
        @(negedge clk);
        en = 1'b0;
        repeat (30) tick();
        check("gate_one_sent", 64'(send_seen - base), 64'h1);
        check("gate_count2", 64'(o_count), 64'h2);
        check("gate_idle_tx", 64'(is_sending), 64'h0);
        @(negedge clk);
        en = 1'b1;
        drain("gate", 200);
        check("gate_all_sent", 64'(send_seen - base), 64'h3);

        // Reset in BUSY with 4 queued words
        for (int i = 0; i < 4; i++) wr(32'hC000_0000 + 32'(i), 2'(i), 1'b1);
        wait_busy("rst_busy");
        check("rst_pre_count", 64'(o_count != 4'd0), 64'h1);
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        sb_q.delete();
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        base = send_seen;
        wr(32'hCAFE_F00D, 2'd1, 1'b1);
        exp_send_edge = cyc + 2;
        drain("post_rst", 100);
        check("post_rst_sent", 64'(send_seen - base), 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tx_msg_feeder.md
# tx_msg_feeder

Buffers 32-bit messages and their spreading-factor selections in a small FIFO and launches them one at a time into the DCSK transmitter (`tx`) through its `i_send`/`i_msg`/`i_sf` inputs. Sits directly upstream of `tx`. It uses the transmitter's `o_is_sending` to sequence frames back-to-back, so a producer can queue bursts without tracking transmitter timing. It also detects a transmitter that never starts a requested frame.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `START_TIMEOUT`, 4: cycles after launch within which `i_is_sending` must rise.
- `i_clk`  in  1  system clock; all logic on rising edge.
- `i_arst_n`  in  1  reset, asynchronous and active-low. This is already decided.
- `i_wr_en`  in  1  write request; sampled on the rising edge.
- `i_wr_msg`  in  32  message word to queue.
- `i_wr_sf`  in  2  spreading factor as `sf_t`: 0=SF4, 1=SF8, 2=SF16, 3=SF32.
- `i_en`  in  1  launch enable; when low, no new frame starts.
- `i_is_sending`  in  1  from `tx.o_is_sending`.
- `o_send`  out  1  to `tx.i_send`; one-cycle pulse.
- `o_msg`  out  32  to `tx.i_msg`.
- `o_sf`  out  2  to `tx.i_sf`.
- `o_full`  out  1  FIFO holds `DEPTH` entries.
- `o_empty`  out  1  FIFO holds 0 entries.
- `o_count`  out  $clog2(DEPTH)+1  current occupancy.
- `o_ovf`  out  1  sticky; a write was attempted while full.
- `o_timeout`  out  1  sticky; the transmitter failed to start a launched frame.
- `i_clr_err`  in  1  synchronous clear of `o_ovf` and `o_timeout`.

## Operation
- **FIFO**
  - Stores 34-bit entries `{sf, msg}`, with read/write pointers of width $clog2(DEPTH)+1 that wrap naturally.
  - A write is accepted iff `i_wr_en && !o_full` at the edge. A pop in the same cycle does not make room for a write in that cycle.
  - A write attempted while full is dropped and sets `o_ovf`.
  - A simultaneous accepted write and pop leaves `o_count` unchanged.
- **FSM states**
  - IDLE:
    - Go to LAUNCH when `i_en && !o_empty`.
    - On that transition, pop the head entry into the `o_msg`/`o_sf` registers.
  - LAUNCH:
    - `o_send`=1 for exactly this one cycle.
    - Load the timeout counter with `START_TIMEOUT`.
    - Go to WAIT_START.
  - WAIT_START:
    - If `i_is_sending`=1, go to BUSY.
    - Otherwise decrement the counter. When it reaches 0, set `o_timeout` and go to IDLE; the frame is discarded and not retried.
  - BUSY: when `i_is_sending`=0, go to GAP.
  - GAP: one idle cycle so `tx` sees `i_send` low before the next pulse; go to IDLE.
- `o_msg`/`o_sf` hold their value from the pop until the next pop. They are therefore stable throughout the frame.
- `i_en` low does not abort a frame in progress. It only blocks the IDLE->LAUNCH transition.
- If `i_clr_err` and a new error event occur in the same cycle, the error wins and the flag stays 1.
- `i_is_sending` high while in IDLE (transmitter driven by someone else) blocks launch until it is low.

## Timing
- **Reset values**
  - `o_send`=0, `o_msg`=0, `o_sf`=0, `o_full`=0, `o_empty`=1, `o_count`=0, `o_ovf`=0, `o_timeout`=0.
  - FSM in IDLE; pointers 0; FIFO contents are don't-care.
- **Reset asserted mid-frame:** all of the above apply immediately and asynchronously, and queued entries are lost. After release, the FSM waits in IDLE for new writes.
- **Latency, empty FIFO in IDLE with `i_en`=1:**
  - Write accepted at edge k; `o_empty` falls after edge k.
  - IDLE->LAUNCH at edge k+1; `o_msg`/`o_sf` are valid after edge k+1.
  - `o_send` is high from edge k+2 to edge k+3.
- **Back-to-back frames:** the next `o_send` rises 3 edges after the edge at which `i_is_sending`=0 is sampled (BUSY->GAP->IDLE->LAUNCH).
- **Timeout window:** `o_timeout` sets at the `START_TIMEOUT`-th edge after LAUNCH with no `i_is_sending` seen.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Single frame:**
  - Reset, write `32'hDEADBEEF` with SF32 while `tx` is connected.
  - Required: one `o_send` pulse 2 edges after the write, with `o_msg`=DEADBEEF and `o_sf`=3 stable until `i_is_sending` falls.
  - `Demod_Top` outputs DEADBEEF.
- **Burst and ordering:**
  - Queue 8 random words with SF4/8/16/32 cycling.
  - Required: `o_full`=1 after the 8th write, and 8 frames launched in write order.
  - The next `o_send` follows each `i_is_sending` fall by 3 edges; `o_empty`=1 at the end.
- **Overflow:**
  - With `i_en`=0, write 9 words.
  - Required: `o_count`=8, `o_ovf`=1, and the 9th word is never sent.
  - `i_clr_err` clears `o_ovf`.
- **Timeout:**
  - Hold `i_is_sending`=0 with `tx` disconnected, then queue 2 words.
  - Required: `o_timeout`=1 four edges after each launch.
  - Both words are consumed and `o_count`=0.
- **Enable gating:**
  - Drop `i_en` mid-frame while 3 words are queued.
  - Required: the current frame completes and no further `o_send` occurs.
  - On re-raising `i_en`, launch resumes with the next word.
- **Reset mid-frame:**
  - Assert `i_arst_n`=0 during BUSY with 4 queued words.
  - Required: all outputs take their reset values within the same cycle, and `o_count`=0.
  - After release, a new write launches normally.
